multi_channel_ring_buffer: RTL and testbench
============================================

Name: multi_channel_ring_buffer

Overview:
Multi-channel successor to the plain dual-port buffer. It manages its own pointers and keeps NumChannels independent circular FIFOs in one shared storage array. The write side takes beats from the PHY/backend, and the read side returns them to the cache/frontend through a registered valid/ready output stage. Per-channel full, empty and count replace the external pointer and hazard logic.

Parameters:
NumChannels, 4, number of independent logical FIFOs (>=1)
Depth, 8, entries per channel (>=2, need not be a power of two)
DataWidth, 64, bits per entry
ChW (derived), max(1,$clog2(NumChannels)), channel-id width
CntW (derived), $clog2(Depth+1), per-channel count width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wr_valid  in  1  write beat offered
wr_ready  out  NumChannels==1 ? 1 : 1  beat accepted; combinational = !full[wr_ch] && wr_ch<NumChannels
wr_ch  in  ChW  target channel of write
wr_data  in  DataWidth  write payload
rd_req  in  1  pop request
rd_req_ready  out  1  pop accepted this cycle
rd_ch  in  ChW  channel to pop
rd_valid  out  1  output stage holds data
rd_ready  in  1  consumer takes output
rd_data  out  DataWidth  popped payload
rd_ch_out  out  ChW  channel the rd_data came from
empty  out  NumChannels  per-channel empty flag
full  out  NumChannels  per-channel full flag
count  out  NumChannels*CntW  per-channel occupancy, channel i at [i*CntW +: CntW]

Behaviour:
- Reset (async, rst=0): all wptr/rptr=0, all counts=0, empty=all 1, full=all 0, rd_valid=0, rd_data=0, rd_ch_out=0. Storage contents are don't-care.
- Write handshake: fire when wr_valid && wr_ready. Writes mem[wr_ch][wptr[wr_ch]]. wptr advances and wraps from Depth-1 to 0. count+1.
- Pop accept: rd_req_ready = rd_req && rd_ch<NumChannels && !empty[rd_ch] && (!rd_valid || rd_ready).
- On accept, the next edge loads rd_data=mem[rd_ch][rptr[rd_ch]] and rd_ch_out=rd_ch, and sets rd_valid=1. rptr advances with wrap. count-1. Latency is one cycle from accept to rd_valid.
- Output stage: rd_valid && rd_ready with no new accept clears rd_valid next cycle. rd_data/rd_ch_out hold while rd_valid && !rd_ready. Back-to-back accepts give one beat per cycle.
- Same channel, same cycle, write and pop: count unchanged, both pointers advance. Pop of an empty channel is refused even if a write to it fires that cycle (no bypass). A write to a full channel is refused even if a pop of it fires that cycle.
- A pop reads the entry written in an earlier cycle only. A read and a write never target the same slot in the same cycle, so no RAW hazard exists.
- empty/full/count are registered-state derived: empty = (count==0), full = (count==Depth).
- Out-of-range channel ids (>=NumChannels) are ignored: wr_ready=0, rd_req_ready=0.
- Channels are fully independent. Activity on one never changes another's pointers or count.
- Reset mid-operation: all state returns to reset values immediately; any held output beat is discarded.

Optional Feature:
MCRB_FLUSH_EN: adds input flush [NumChannels].
- flush[i]=1 sets wptr[i], rptr[i] and count[i] to 0 at the next edge.
- Flush has priority over a same-cycle write or pop on channel i; that write/pop still handshakes but is dropped.
- A beat already in the output stage is not cancelled.
- Without the macro: no flush port; the channel state changes only by write/pop.

Test Plan:
1. Reset, then write ch2 data 0xA1,0xA2,0xA3 and pop ch2 three times with rd_ready=1 -> rd_data 0xA1,0xA2,0xA3 on consecutive cycles, rd_ch_out=2; count[2] goes 3→0; empty[2]=1.
2. Fill ch0 with 8 beats (Depth=8) -> full[0]=1, 9th wr_valid gets wr_ready=0. Pop 1 and write 1 more -> pointer wrap; next 8 pops return beats 2..9 in order.
3. Pop empty ch1 while writing ch1 0x55 in the same cycle -> rd_req_ready=0. Next cycle the pop is accepted, and 0x55 appears one cycle later.
4. Hold rd_ready=0 with rd_valid=1 and issue rd_req on ch3 -> rd_req_ready=0, rd_data stable. Raise rd_ready -> pops resume one per cycle.
5. Interleave writes ch0/ch1 and pops ch1/ch0 each cycle for 100 random cycles -> per-channel order preserved, counts match the scoreboard, no cross-channel corruption.
6. (MCRB_FLUSH_EN) ch0 holds 5 beats; assert flush[0] with a simultaneous write -> count[0]=0 and empty[0]=1 next cycle; the next pop of ch0 is refused.

Source files
------------

// File: rtl/multi_channel_ring_buffer_if.sv
// Handshake/status bundle for multi_channel_ring_buffer.
// Build option: define MCRB_FLUSH_EN to add the per-channel flush input.
//   wr_valid/wr_ready/wr_ch/wr_data   : write beat from PHY/backend side
//   rd_req/rd_req_ready/rd_ch         : pop request into the output stage
//   rd_valid/rd_ready/rd_data/rd_ch_out: registered output stage to the frontend
//   empty/full/count                   : per-channel status, count of channel i at [i*CntW +: CntW]
//   flush (MCRB_FLUSH_EN only)          : per-channel clear
// The master modport drives the requests; the slave modport is the buffer.
interface multi_channel_ring_buffer_if #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned Depth       = 8,
    parameter int unsigned DataWidth   = 64
);
    localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic                        wr_valid;
    logic                        wr_ready;
    logic [ChW-1:0]              wr_ch;
    logic [DataWidth-1:0]        wr_data;
    logic                        rd_req;
    logic                        rd_req_ready;
    logic [ChW-1:0]              rd_ch;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [DataWidth-1:0]        rd_data;
    logic [ChW-1:0]              rd_ch_out;
    logic [NumChannels-1:0]      empty;
    logic [NumChannels-1:0]      full;
    logic [NumChannels*CntW-1:0] count;
`ifdef MCRB_FLUSH_EN
    logic [NumChannels-1:0]      flush;
`endif

    modport master (
        output wr_valid, wr_ch, wr_data, rd_req, rd_ch, rd_ready,
`ifdef MCRB_FLUSH_EN
        output flush,
`endif
        input  wr_ready, rd_req_ready, rd_valid, rd_data, rd_ch_out, empty, full, count
    );

    modport slave (
        input  wr_valid, wr_ch, wr_data, rd_req, rd_ch, rd_ready,
`ifdef MCRB_FLUSH_EN
        input  flush,
`endif
        output wr_ready, rd_req_ready, rd_valid, rd_data, rd_ch_out, empty, full, count
    );
endinterface

// File: rtl/multi_channel_ring_buffer.sv
// NumChannels independent circular FIFOs sharing one storage array, with a
// registered valid/ready output stage on the read side.
// Build option: define MCRB_FLUSH_EN to enable the per-channel flush input.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : multi_channel_ring_buffer_if.slave (write, pop, output stage, status)
module multi_channel_ring_buffer #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned Depth       = 8,
    parameter int unsigned DataWidth   = 64
) (
    input logic                        clk,
    input logic                        rst,
    multi_channel_ring_buffer_if.slave bus
);
    localparam int unsigned ChW   = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned Slots = NumChannels * Depth;
    localparam int unsigned AddrW = (Slots > 1) ? $clog2(Slots) : 1;

    localparam logic [ChW:0]    ChLimit = (ChW + 1)'(NumChannels);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    // Channel c owns slots [c*Depth, c*Depth+Depth).
    logic [DataWidth-1:0] mem [Slots];

    logic [PtrW-1:0] wptr_q [NumChannels];
    logic [PtrW-1:0] wptr_d [NumChannels];
    logic [PtrW-1:0] rptr_q [NumChannels];
    logic [PtrW-1:0] rptr_d [NumChannels];
    logic [CntW-1:0] cnt_q  [NumChannels];
    logic [CntW-1:0] cnt_d  [NumChannels];

    logic                 rd_valid_q;
    logic [DataWidth-1:0] rd_data_q;
    logic [ChW-1:0]       rd_ch_out_q;

    logic [NumChannels-1:0] empty_vec, full_vec, wr_hit, rd_hit;
    logic                   wr_in_range, rd_in_range, wr_full_sel, rd_empty_sel;
    logic [PtrW-1:0]        wptr_sel, rptr_sel;
    logic                   wr_ready, wr_fire, rd_accept;
    logic [AddrW-1:0]       wr_addr, rd_addr;

    // Status flags and per-channel selection by the requested channel ids.
    always_comb begin
        wr_full_sel  = 1'b0;
        rd_empty_sel = 1'b1;
        wptr_sel     = '0;
        rptr_sel     = '0;
        empty_vec    = '0;
        full_vec     = '0;
        for (int i = 0; i < NumChannels; i++) begin
            empty_vec[i] = (cnt_q[i] == '0);
            full_vec[i]  = (cnt_q[i] == CntFull);
            if (bus.wr_ch == ChW'(i)) begin
                wr_full_sel = full_vec[i];
                wptr_sel    = wptr_q[i];
            end
            if (bus.rd_ch == ChW'(i)) begin
                rd_empty_sel = empty_vec[i];
                rptr_sel     = rptr_q[i];
            end
        end
    end

    assign wr_in_range = ({1'b0, bus.wr_ch} < ChLimit);
    assign rd_in_range = ({1'b0, bus.rd_ch} < ChLimit);

    // Status comes from registered counts only, so a same-cycle pop never
    // frees room for a write and a same-cycle write never feeds a pop.
    assign wr_ready  = wr_in_range && !wr_full_sel;
    assign wr_fire   = bus.wr_valid && wr_ready;
    assign rd_accept = bus.rd_req && rd_in_range && !rd_empty_sel &&
                       (!rd_valid_q || bus.rd_ready);

    assign wr_addr = AddrW'(bus.wr_ch) * AddrW'(Depth) + AddrW'(wptr_sel);
    assign rd_addr = AddrW'(bus.rd_ch) * AddrW'(Depth) + AddrW'(rptr_sel);

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < NumChannels; i++) begin
            wr_hit[i] = wr_fire && (bus.wr_ch == ChW'(i));
            rd_hit[i] = rd_accept && (bus.rd_ch == ChW'(i));
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wr_hit[i]) wptr_d[i] = (wptr_q[i] == PtrLast) ? '0 : wptr_q[i] + PtrW'(1);
            if (rd_hit[i]) rptr_d[i] = (rptr_q[i] == PtrLast) ? '0 : rptr_q[i] + PtrW'(1);
            case ({wr_hit[i], rd_hit[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
`ifdef MCRB_FLUSH_EN
            // Flush wins; a same-cycle write/pop still handshakes but its
            // pointer/count effect is dropped.
            if (bus.flush[i]) begin
                wptr_d[i] = '0;
                rptr_d[i] = '0;
                cnt_d[i]  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumChannels; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_ch_out_q <= '0;
        end else begin
            for (int i = 0; i < NumChannels; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            if (rd_accept) begin
                rd_valid_q  <= 1'b1;
                rd_data_q   <= mem[rd_addr];
                rd_ch_out_q <= bus.rd_ch;
            end else if (bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= bus.wr_data;
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.rd_req_ready = rd_accept;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_ch_out    = rd_ch_out_q;
    assign bus.empty        = empty_vec;
    assign bus.full         = full_vec;

    always_comb begin
        bus.count = '0;
        for (int i = 0; i < NumChannels; i++) begin
            bus.count[i*CntW +: CntW] = cnt_q[i];
        end
    end
endmodule

// File: tb/tb_multi_channel_ring_buffer.sv
module tb_multi_channel_ring_buffer;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = 4;

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_channel_ring_buffer_if #(.NumChannels(NCH), .Depth(DEPTH), .DataWidth(DW)) bus ();

    multi_channel_ring_buffer #(.NumChannels(NCH), .Depth(DEPTH), .DataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one plain queue per channel plus the expected output beats.
    logic [DW-1:0] mq [NCH][$];
    beat_t         expq [$];
    bit            m_out_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " count"}, bus.count, '0);
        chk({tag, " empty"}, bus.empty, 4'hF);
        chk({tag, " full"}, bus.full, 4'h0);
        chk({tag, " rd_valid"}, bus.rd_valid, 1'b0);
        chk({tag, " rd_data"}, bus.rd_data, '0);
        chk({tag, " rd_ch_out"}, bus.rd_ch_out, '0);
    endtask

    // Monitor: every transfer out of the output stage must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst && bus.rd_valid && bus.rd_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got ch %0d data 0x%0h, expected no beat",
                         bus.rd_ch_out, bus.rd_data);
            end else begin
                beat_t e;
                e = expq.pop_front();
                chk("rd_data", bus.rd_data, e.data);
                chk("rd_ch_out", bus.rd_ch_out, {62'd0, e.ch});
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit wv, input int wch, input logic [DW-1:0] wd,
                        input bit rq, input int rch, input bit rr);
        bit    exp_wr, exp_rd;
        beat_t b;
        bus.wr_valid = wv;
        bus.wr_ch    = 2'(wch);
        bus.wr_data  = wd;
        bus.rd_req   = rq;
        bus.rd_ch    = 2'(rch);
        bus.rd_ready = rr;
        @(negedge clk);
        exp_wr = (wch < NCH) && (mq[wch].size() < DEPTH);
        exp_rd = rq && (rch < NCH) && (mq[rch].size() > 0) && (!m_out_valid || rr);
        chk("wr_ready", bus.wr_ready, exp_wr);
        chk("rd_req_ready", bus.rd_req_ready, exp_rd);
        chk("rd_valid", bus.rd_valid, m_out_valid);
        if (m_out_valid && !rr && expq.size() > 0) chk("held rd_data", bus.rd_data, expq[0].data);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count[%0d]", c), bus.count[c*CW +: CW], mq[c].size());
            chk($sformatf("empty[%0d]", c), bus.empty[c], mq[c].size() == 0);
            chk($sformatf("full[%0d]", c), bus.full[c], mq[c].size() == DEPTH);
        end
        if (exp_rd) begin
            b.ch   = 2'(rch);
            b.data = mq[rch].pop_front();
            expq.push_back(b);
        end
        if (wv && exp_wr) mq[wch].push_back(wd);
`ifdef MCRB_FLUSH_EN
        for (int c = 0; c < NCH; c++) if (bus.flush[c]) mq[c].delete();
`endif
        m_out_valid = exp_rd || (m_out_valid && !rr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, 1);
    endtask

    initial begin
        bus.wr_valid = 0; bus.wr_ch = 0; bus.wr_data = 0;
        bus.rd_req = 0; bus.rd_ch = 0; bus.rd_ready = 1;
`ifdef MCRB_FLUSH_EN
        bus.flush = '0;
`endif
        m_out_valid = 0;
        rst = 1;
        #1 rst = 0;
        #1 chk_reset("reset");
        @(posedge clk);
        #1 chk_reset("reset held");
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;

        // 1: three beats through ch2
        step(1, 2, 64'hA1, 0, 0, 1);
        step(1, 2, 64'hA2, 0, 0, 1);
        step(1, 2, 64'hA3, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 2, 1);
        idle(2);

        // 2: fill ch0, refused 9th write, wrap after one pop
        for (int k = 1; k <= 8; k++) step(1, 0, 64'(k), 0, 0, 1);
        step(1, 0, 64'd99, 0, 0, 1);
        step(0, 0, '0, 1, 0, 1);
        step(1, 0, 64'd9, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(0, 0, '0, 1, 0, 1);
        idle(2);

        // 3: pop empty ch1 during its first write; no bypass
        step(1, 1, 64'h55, 1, 1, 1);
        step(0, 0, '0, 1, 1, 1);
        idle(2);

        // 4: stalled output stage blocks pops, then resumes
        for (int k = 0; k < 3; k++) step(1, 3, 64'hC0 + 64'(k), 0, 0, 1);
        step(0, 0, '0, 1, 3, 0);
        step(0, 0, '0, 1, 3, 0);
        step(0, 0, '0, 1, 3, 0);
        step(0, 0, '0, 1, 3, 1);
        step(0, 0, '0, 1, 3, 1);
        idle(2);

        // 5: random interleaving on ch0/ch1
        for (int k = 0; k < 100; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
        end
        idle(4);

        // Reset mid-operation discards the held beat and all channel state
        step(1, 2, 64'h77, 0, 0, 1);
        step(0, 0, '0, 1, 2, 0);
        #2 rst = 0;
        #1 chk_reset("mid reset");
        for (int c = 0; c < NCH; c++) mq[c].delete();
        expq.delete();
        m_out_valid = 0;
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        idle(1);

`ifdef MCRB_FLUSH_EN
        // 6: flush with a simultaneous write empties ch0
        for (int k = 0; k < 5; k++) step(1, 0, 64'hF0 + 64'(k), 0, 0, 1);
        bus.flush = 4'b0001;
        step(1, 0, 64'hEE, 0, 0, 1);
        bus.flush = '0;
        step(0, 0, '0, 1, 0, 1);
        idle(2);
`endif

        chk("expected beats drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
